debug_display_sequencer: RTL and testbench

//  Parametrised, registered successor to the combinational display debug mux. Selects one of

---
 rtl/debug_display_sequencer_if.sv | 19 +
 rtl/debug_display_sequencer.sv | 172 +++++++++++++++++
 tb/tb_debug_display_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/debug_display_sequencer_if.sv
// ---------------------------------------------------------------------------
// debug_display_sequencer_if
// Bundles the processor debug taps that feed the display sequencer.
//   chan_data  : flattened debug words, channel k = [k*DATA_W +: DATA_W]
//   chan_valid : one bit per channel slot, 1 = slot is populated
// Modports:
//   master : the tap side (processor / board top level) driving the words
//   slave  : the sequencer consuming them
// ---------------------------------------------------------------------------
interface debug_display_sequencer_if #(
   parameter int DATA_W   = 32,
   parameter int CHANNELS = 64
);
   logic [CHANNELS*DATA_W-1:0] chan_data;
   logic [CHANNELS-1:0]        chan_valid;

   modport master (output chan_data, output chan_valid);
   modport slave  (input  chan_data, input  chan_valid);
endinterface

// File: rtl/debug_display_sequencer.sv
// ---------------------------------------------------------------------------
// debug_display_sequencer
// Registered selector of one debug channel for the 8-digit HEX display, with
// manual select, auto-scan, button-step and freeze/snapshot modes. Unpopulated
// channels are skipped when advancing and shown as ERR_PATTERN when selected.
// Ports:
//   clk_i              system clock, rising edge
//   rst_i              synchronous, active-high reset
//   tap                debug channel words and populated flags (slave side)
//   display_select_i   manual channel index
//   mode_i             0 manual, 1 auto-scan, 2 step, 3 treated as manual
//   step_i             debounced step button level, rising edge advances
//   freeze_i           level, holds a snapshot of the displayed word
//   display_blank_i    forces OFF_PATTERN
//   hex_display_o      registered display word
//   current_channel_o  registered index of the channel being shown
//   frozen_o           1 while the snapshot is displayed
//   dwell_tick_o       one-cycle pulse when auto-scan advances
// ---------------------------------------------------------------------------
module debug_display_sequencer #(
   parameter int          DATA_W       = 32,
   parameter int          CHANNELS     = 64,
   parameter int          SEL_W        = 6,
   parameter int          DWELL_CYCLES = 50_000_000,
   parameter logic [31:0] OFF_PATTERN  = 32'h0000_0FF0,
   parameter logic [31:0] ERR_PATTERN  = 32'h0000_DEDE
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   debug_display_sequencer_if.slave tap,
   input  logic [SEL_W-1:0]       display_select_i,
   input  logic [1:0]             mode_i,
   input  logic                   step_i,
   input  logic                   freeze_i,
   input  logic                   display_blank_i,
   output logic [DATA_W-1:0]      hex_display_o,
   output logic [SEL_W-1:0]       current_channel_o,
   output logic                   frozen_o,
   output logic                   dwell_tick_o
);

   localparam int                CNT_W  = $clog2(DWELL_CYCLES);
   localparam logic [CNT_W-1:0]  TERM_C = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [SEL_W:0]    NCH_C  = (SEL_W+1)'(CHANNELS);
   localparam logic [DATA_W-1:0] OFF_W  = DATA_W'(OFF_PATTERN);
   localparam logic [DATA_W-1:0] ERR_W  = DATA_W'(ERR_PATTERN);

   // Word shown for channel idx: ERR for out-of-range or unpopulated slots.
   function automatic logic [DATA_W-1:0] word_of(
      input logic [SEL_W-1:0]           idx,
      input logic [CHANNELS*DATA_W-1:0] data,
      input logic [CHANNELS-1:0]        valid
   );
      logic [DATA_W-1:0] w;
      if ({1'b0, idx} >= NCH_C) begin
         w = ERR_W;
      end else if (!valid[idx]) begin
         w = ERR_W;
      end else begin
         w = data[idx*DATA_W +: DATA_W];
      end
      return w;
   endfunction

   logic [DATA_W-1:0] hex_q, hex_d, snap_q, snap_d, norm_s;
   logic [SEL_W-1:0]  cur_q, cur_d, base_s, nxt_s;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        mode_q;
   logic              tick_q, tick_d, frz_q, step_q, any_valid_s;
   logic              frz_act_s, frz_edge_s, frz_rel_s, step_edge_s, mode_chg_s;
   logic [SEL_W:0]    idx_v;

   // Next populated channel after base_s, scanning downwards so the nearest wins.
   always_comb begin
      nxt_s       = '0;
      any_valid_s = 1'b0;
      idx_v       = '0;
      for (int i = CHANNELS; i >= 1; i--) begin
         idx_v = {1'b0, base_s} + (SEL_W+1)'(i);
         idx_v = (idx_v >= NCH_C) ? (idx_v - NCH_C) : idx_v;
         nxt_s       = tap.chan_valid[idx_v[SEL_W-1:0]] ? idx_v[SEL_W-1:0] : nxt_s;
         any_valid_s = any_valid_s | tap.chan_valid[idx_v[SEL_W-1:0]];
      end
   end

   // Control decode, channel/dwell sequencing and display word selection.
   always_comb begin
      // Freeze only counts when not overridden by blanking.
      frz_act_s   = freeze_i & ~display_blank_i;
      frz_edge_s  = frz_act_s & ~frz_q;
      frz_rel_s   = ~frz_act_s & frz_q;
      step_edge_s = step_i & ~step_q;
      mode_chg_s  = (mode_i != mode_q);
      // An out-of-range manual index is clamped when auto/step takes over.
      base_s      = ({1'b0, cur_q} >= NCH_C) ? '0 : cur_q;
      cur_d       = cur_q;
      cnt_d       = cnt_q;
      tick_d      = 1'b0;
      if (frz_act_s && frz_q) begin
         cur_d = cur_q;
         cnt_d = cnt_q;
      end else begin
         case (mode_i)
            2'd1: begin
               if (mode_chg_s || frz_rel_s) begin
                  cnt_d = '0;
                  cur_d = base_s;
               end else if (cnt_q == TERM_C) begin
                  cnt_d  = '0;
                  cur_d  = nxt_s;
                  tick_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
                  cur_d = base_s;
               end
            end
            2'd2: begin
               cnt_d = '0;
               cur_d = step_edge_s ? nxt_s : base_s;
            end
            default: begin
               cnt_d = '0;
               cur_d = display_select_i;
            end
         endcase
         // With nothing populated, auto/step parks on channel 0.
         if ((mode_i == 2'd1 || mode_i == 2'd2) && !any_valid_s) begin
            cur_d = '0;
         end else begin
            cur_d = cur_d;
         end
      end
      norm_s = word_of(cur_d, tap.chan_data, tap.chan_valid);
      snap_d = frz_edge_s ? norm_s : snap_q;
      if (display_blank_i) begin
         hex_d = OFF_W;
      end else if (frz_act_s) begin
         hex_d = snap_d;
      end else begin
         hex_d = norm_s;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hex_q  <= OFF_W;
         cur_q  <= '0;
         cnt_q  <= '0;
         tick_q <= 1'b0;
         frz_q  <= 1'b0;
         step_q <= 1'b0;
         snap_q <= '0;
         mode_q <= mode_i;
      end else begin
         hex_q  <= hex_d;
         cur_q  <= cur_d;
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
         frz_q  <= frz_act_s;
         step_q <= step_i;
         snap_q <= snap_d;
         mode_q <= mode_i;
      end
   end

   assign hex_display_o     = hex_q;
   assign current_channel_o = cur_q;
   assign frozen_o          = frz_q;
   assign dwell_tick_o      = tick_q;

endmodule

// File: tb/tb_debug_display_sequencer.sv
module tb_debug_display_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  sel;
   logic [1:0]  mode;
   logic        step, freeze, blank;
   logic [31:0] hex;
   logic [5:0]  chan;
   logic        frozen, dtick;
   int          n_cmp = 0;
   int          n_err = 0;

   debug_display_sequencer_if #(.DATA_W(32), .CHANNELS(64)) tap ();

   debug_display_sequencer #(
      .DATA_W(32), .CHANNELS(64), .SEL_W(6), .DWELL_CYCLES(4),
      .OFF_PATTERN(32'h0000_0FF0), .ERR_PATTERN(32'h0000_DEDE)
   ) dut (
      .clk_i(clk), .rst_i(rst), .tap(tap),
      .display_select_i(sel), .mode_i(mode), .step_i(step),
      .freeze_i(freeze), .display_blank_i(blank),
      .hex_display_o(hex), .current_channel_o(chan),
      .frozen_o(frozen), .dwell_tick_o(dtick)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_ch(input int k, input logic [31:0] v);
      tap.chan_data[k*32 +: 32] = v;
   endtask

   initial begin
      logic [5:0]  exp_ch;
      logic [31:0] exp_w;
      rst = 1'b1; sel = 6'd0; mode = 2'd0; step = 1'b0; freeze = 1'b0; blank = 1'b0;
      tap.chan_data  = '0;
      tap.chan_valid = '0;
      tick();
      chk("reset_hex", hex, 32'h0000_0FF0);
      chk("reset_ch", {26'd0, chan}, 32'd0);
      chk("reset_frozen", {31'd0, frozen}, 32'd0);
      chk("reset_tick", {31'd0, dtick}, 32'd0);

      // T1 manual select, then an unpopulated slot
      rst = 1'b0;
      tap.chan_valid[2] = 1'b1;
      set_ch(2, 32'h1234_5678);
      sel = 6'd2;
      tick();
      chk("t1_hex", hex, 32'h1234_5678);
      chk("t1_ch", {26'd0, chan}, 32'd2);
      sel = 6'd63;
      tick();
      chk("t1_err_hex", hex, 32'h0000_DEDE);
      chk("t1_err_ch", {26'd0, chan}, 32'd63);

      // T2 auto-scan over {0,3,5}, dwell 4
      tap.chan_valid = '0;
      tap.chan_valid[0] = 1'b1; tap.chan_valid[3] = 1'b1; tap.chan_valid[5] = 1'b1;
      set_ch(0, 32'hA0A0_0000); set_ch(3, 32'hA3A3_0003); set_ch(5, 32'hA5A5_0005);
      sel = 6'd0; mode = 2'd1; rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int e = 1; e <= 13; e++) begin
         tick();
         exp_ch = (e < 4) ? 6'd0 : (e < 8) ? 6'd3 : (e < 12) ? 6'd5 : 6'd0;
         exp_w  = (exp_ch == 6'd3) ? 32'hA3A3_0003 : (exp_ch == 6'd5) ? 32'hA5A5_0005 : 32'hA0A0_0000;
         chk($sformatf("t2_ch_%0d", e), {26'd0, chan}, {26'd0, exp_ch});
         chk($sformatf("t2_hex_%0d", e), hex, exp_w);
         chk($sformatf("t2_tick_%0d", e), {31'd0, dtick}, {31'd0, (e % 4 == 0)});
      end

      // T3 step mode over {0,1,2}
      tap.chan_valid = '0;
      tap.chan_valid[0] = 1'b1; tap.chan_valid[1] = 1'b1; tap.chan_valid[2] = 1'b1;
      set_ch(1, 32'hB1B1_0001); set_ch(2, 32'hB2B2_0002);
      mode = 2'd2;
      tick();
      chk("t3_start_ch", {26'd0, chan}, 32'd0);
      step = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         tick();
         chk($sformatf("t3_hold_ch_%0d", c), {26'd0, chan}, 32'd1);
      end
      chk("t3_hold_hex", hex, 32'hB1B1_0001);
      step = 1'b0; tick();
      step = 1'b1; tick();
      chk("t3_step2_ch", {26'd0, chan}, 32'd2);
      chk("t3_step2_hex", hex, 32'hB2B2_0002);
      step = 1'b0; tick();
      step = 1'b1; tick();
      chk("t3_wrap_ch", {26'd0, chan}, 32'd0);
      chk("t3_wrap_hex", hex, 32'hA0A0_0000);
      step = 1'b0;

      // T4 freeze during auto-scan on ch1
      mode = 2'd0; sel = 6'd1;
      set_ch(1, 32'h0000_AAAA);
      tick();
      mode = 2'd1;
      tick();
      chk("t4_pre_hex", hex, 32'h0000_AAAA);
      freeze = 1'b1;
      tick();
      chk("t4_cap_hex", hex, 32'h0000_AAAA);
      chk("t4_cap_frozen", {31'd0, frozen}, 32'd1);
      set_ch(1, 32'h0000_BBBB);
      for (int c = 1; c <= 6; c++) begin
         tick();
         chk($sformatf("t4_frz_hex_%0d", c), hex, 32'h0000_AAAA);
         chk($sformatf("t4_frz_flag_%0d", c), {31'd0, frozen}, 32'd1);
         chk($sformatf("t4_frz_tick_%0d", c), {31'd0, dtick}, 32'd0);
         chk($sformatf("t4_frz_ch_%0d", c), {26'd0, chan}, 32'd1);
      end
      freeze = 1'b0;
      tick();
      chk("t4_rel_hex", hex, 32'h0000_BBBB);
      chk("t4_rel_frozen", {31'd0, frozen}, 32'd0);
      for (int c = 1; c <= 4; c++) begin
         tick();
         chk($sformatf("t4_dwell_tick_%0d", c), {31'd0, dtick}, {31'd0, (c == 4)});
         chk($sformatf("t4_dwell_ch_%0d", c), {26'd0, chan}, (c == 4) ? 32'd2 : 32'd1);
      end

      // T5 blank overrides freeze; nothing populated
      blank = 1'b1; freeze = 1'b1;
      tick();
      chk("t5_blank_hex", hex, 32'h0000_0FF0);
      chk("t5_blank_frozen", {31'd0, frozen}, 32'd0);
      blank = 1'b0; freeze = 1'b0; mode = 2'd2;
      tap.chan_valid = '0;
      tick();
      chk("t5_none_hex", hex, 32'h0000_DEDE);
      chk("t5_none_ch", {26'd0, chan}, 32'd0);

      // T6 reset mid-freeze and mid-dwell
      tap.chan_valid[0] = 1'b1; tap.chan_valid[3] = 1'b1; tap.chan_valid[5] = 1'b1;
      mode = 2'd1;
      tick(); tick(); tick();
      freeze = 1'b1;
      tick(); tick();
      chk("t6_pre_frozen", {31'd0, frozen}, 32'd1);
      rst = 1'b1;
      tick();
      chk("t6_rst_hex", hex, 32'h0000_0FF0);
      chk("t6_rst_ch", {26'd0, chan}, 32'd0);
      chk("t6_rst_frozen", {31'd0, frozen}, 32'd0);
      rst = 1'b0; freeze = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         tick();
         chk($sformatf("t6_tick_%0d", c), {31'd0, dtick}, {31'd0, (c == 4)});
         chk($sformatf("t6_ch_%0d", c), {26'd0, chan}, (c == 4) ? 32'd3 : 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
